i2s_src_arbiter: RTL and testbench
==================================

I2S_SRC_ARBITER -- requirements
Module: i2s_src_arbiter

Interface
REQ-001 SHALL have parameter NUM_SRC, default 4: number of audio source ports, 2..8.
REQ-002 SHALL have parameter DATA_W, default 32: frame width, {L[15:0],R[15:0]} packed.
REQ-003 SHALL have parameter BURST_LEN, default 8: maximum frames per grant, 1..256.
REQ-004 SHALL have port aud_mclk  in  1: sole clock; all logic rising-edge.
REQ-005 SHALL have port aud_mrst  in  1: reset, synchronous, active-high.
REQ-006 SHALL have port src_data_i  in  NUM_SRC*DATA_W: per-source frame; source k occupies bits [k*DATA_W +: DATA_W].
REQ-007 SHALL have port src_valid_i  in  NUM_SRC: per-source frame valid.
REQ-008 SHALL have port src_ready_o  out  NUM_SRC: per-source ready; at most one bit high.
REQ-009 SHALL have port src_en_i  in  NUM_SRC: source enable mask.
REQ-010 SHALL have port dst_data_o  out  DATA_W: registered frame to the I2S generator.
REQ-011 SHALL have port dst_valid_o  out  1: registered frame valid.
REQ-012 SHALL have port dst_ready_i  in  1: I2S generator frame request.
REQ-013 SHALL have port grant_idx_o  out  $clog2(NUM_SRC): current or last granted source.
REQ-014 SHALL have port busy_o  out  1: high in S_GRANT.
REQ-015 SHALL have port underrun_cnt_o  out  16: saturating underrun counter.

Function
REQ-016 SHALL implement FSM {S_IDLE, S_GRANT}.
REQ-017 In S_IDLE, candidates SHALL be sources with src_valid_i & src_en_i; the winner is the first candidate round-robin from (last_grant+1) mod NUM_SRC, with wrap; on any candidate: go to S_GRANT, burst_cnt<=0, grant_idx_o<=winner.
REQ-018 src_ready_o SHALL be 0 for all sources in S_IDLE; arbitration costs exactly one cycle.
REQ-019 In S_GRANT, src_ready_o[g] SHALL = src_en_i[g] & (!dst_valid_o | dst_ready_i).
REQ-020 On src_valid_i[g] & src_ready_o[g], dst_data_o<=src frame and dst_valid_o<=1 next cycle (latency 1); burst_cnt increments.
REQ-021 dst_valid_o SHALL clear after dst_ready_i with no new load; dst_data_o SHALL hold while dst_valid_o & !dst_ready_i.
REQ-022 S_GRANT SHALL exit to S_IDLE, with last_grant<=g, on: transfer with burst_cnt==BURST_LEN-1; src_valid_i[g]==0 while src_ready_o[g]==1; or src_en_i[g]==0.
REQ-023 An exit on src_en_i[g]==0 SHALL not drop the already-registered output frame; it still completes its handshake.
REQ-024 Simultaneous transfer and burst-end SHALL accept that frame, then exit.
REQ-025 A source held invalid SHALL never be granted; a disabled source SHALL be skipped in round-robin order.
REQ-026 underrun_cnt_o SHALL increment, saturating at 16'hFFFF, per cycle with dst_ready_i & !dst_valid_o (see REQ-029).

Reset
REQ-027 On aud_mrst: state=S_IDLE, last_grant=NUM_SRC-1 (so source 0 wins first), burst_cnt=0, dst_valid_o=0, dst_data_o=0, src_ready_o=0, grant_idx_o=0, busy_o=0, underrun_cnt_o=0.
REQ-028 Reset mid-burst SHALL discard the registered frame without a handshake; no source frame is consumed in the reset cycle.

Configuration
REQ-029 Macro I2S_ARB_SILENCE_FILL_EN:
  - Defined: in S_IDLE with dst_valid_o==0 and no candidate, dst_data_o<=0 and dst_valid_o<=1 (silence frame); underrun_cnt_o counts silence frames inserted, not idle ready cycles.
  - Undefined: no fill; counting per REQ-026.

Structure
REQ-030 Package i2s_pkg SHALL hold the FSM state typedef arb_state_t, the frame typedef aud_frame_t (16-bit L/R struct) and the constant I2S_FRAME_W=32.
REQ-031 Sub-module rr_pick SHALL hold the combinational round-robin priority pick (mask, last index -> winner, found); there SHALL be no other sub-modules.

Verification
REQ-032 Src0 and src2 valid continuously, BURST_LEN=8, dst_ready_i=1 -> 8 frames from src0, 1 gap cycle, 8 from src2, alternating; grant_idx_o toggles 0/2.
REQ-033 Src1 sends 3 frames then drops valid -> grant ends after the 3rd frame; next grant goes to next valid index >1 (wrap to 0).
REQ-034 dst_ready_i=0 for 5 cycles with dst_valid_o=1, data 32'h1234_5678 -> dst_data_o stable for all 5, src_ready_o all 0; frame delivered once on release.
REQ-035 src_en_i[g] cleared mid-burst -> src_ready_o[g] low the same cycle, pending output frame delivered, FSM in S_IDLE the next cycle.
REQ-036 No sources, dst_ready_i=1 for 10 cycles -> undefined macro: underrun_cnt_o=10; defined: 10 zero frames, underrun_cnt_o=10; 70000 such cycles -> 16'hFFFF.
REQ-037 aud_mrst pulsed during a burst -> next cycle all outputs at REQ-027 values; first grant after release goes to src0.

Source files
------------

// File: rtl/i2s_pkg.sv
// Shared types for the I2S source arbiter: FSM state, L/R frame layout and frame width.
package i2s_pkg;

  localparam int I2S_FRAME_W = 32;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } arb_state_t;

  typedef struct packed {
    logic [15:0] l;
    logic [15:0] r;
  } aud_frame_t;

endpackage

// File: rtl/i2s_src_arbiter_rr_pick.sv
// Combinational round-robin pick: first set bit of mask searching upward from last+1, wrapping.
module rr_pick #(
  parameter int NUM_SRC = 4
) (
  input  logic [NUM_SRC-1:0]         mask,
  input  logic [$clog2(NUM_SRC)-1:0] last,
  output logic [$clog2(NUM_SRC)-1:0] winner,
  output logic                       found
);

  localparam int IW = $clog2(NUM_SRC);

  logic [2*NUM_SRC-1:0] dbl;
  logic [NUM_SRC-1:0]   rot;
  int                   cand;

  always_comb begin
    // Bit j of rot is source (last+1+j) mod NUM_SRC.
    dbl    = {mask, mask} >> (int'(last) + 1);
    rot    = dbl[NUM_SRC-1:0];
    found  = 1'b0;
    winner = '0;
    cand   = 0;
    for (int j = NUM_SRC - 1; j >= 0; j--) begin
      if (rot[j]) begin
        found = 1'b1;
        cand  = int'(last) + 1 + j;
        if (cand >= NUM_SRC) cand = cand - NUM_SRC;
        winner = IW'(cand);
      end
    end
  end

endmodule

// File: rtl/i2s_src_arbiter.sv
// Round-robin arbiter feeding one registered I2S frame slot from NUM_SRC sources in bursts.
// Optional silence fill in idle is enabled by defining I2S_ARB_SILENCE_FILL_EN.
module i2s_src_arbiter
  import i2s_pkg::*;
#(
  parameter int NUM_SRC   = 4,
  parameter int DATA_W    = 32,
  parameter int BURST_LEN = 8
) (
  input  logic                         aud_mclk,
  input  logic                         aud_mrst,
  input  logic [NUM_SRC*DATA_W-1:0]    src_data_i,
  input  logic [NUM_SRC-1:0]           src_valid_i,
  output logic [NUM_SRC-1:0]           src_ready_o,
  input  logic [NUM_SRC-1:0]           src_en_i,
  output logic [DATA_W-1:0]            dst_data_o,
  output logic                         dst_valid_o,
  input  logic                         dst_ready_i,
  output logic [$clog2(NUM_SRC)-1:0]   grant_idx_o,
  output logic                         busy_o,
  output logic [15:0]                  underrun_cnt_o,
  output arb_state_t                   dbg_state_o
);

  // Handshakes: a frame moves on a channel only in a cycle where its valid and ready are
  // both high at the rising edge; valid never waits on ready, and the output slot holds its
  // frame and valid until dst_ready_i accepts it.

  localparam int IW = $clog2(NUM_SRC);
  localparam int CW = 9;

  arb_state_t        state_q, state_d;
  logic [IW-1:0]     last_q;
  logic [IW-1:0]     winner;
  logic              found;
  logic [CW-1:0]     burst_q;
  logic              busy, g_en, g_valid, g_ready, xfer, burst_end, exit_grant;
  logic              fill, und_inc;
  logic [DATA_W-1:0] g_frame;

  rr_pick #(.NUM_SRC(NUM_SRC)) u_rr_pick (
    .mask   (src_valid_i & src_en_i),
    .last   (last_q),
    .winner (winner),
    .found  (found)
  );

  always_comb begin
    busy       = (state_q == S_GRANT);
    g_en       = src_en_i[grant_idx_o];
    g_valid    = src_valid_i[grant_idx_o];
    g_frame    = src_data_i[int'(grant_idx_o)*DATA_W +: DATA_W];
    g_ready    = busy & g_en & (~dst_valid_o | dst_ready_i);
    xfer       = g_ready & g_valid;
    burst_end  = xfer & (burst_q == CW'(BURST_LEN - 1));
    exit_grant = busy & (burst_end | (g_ready & ~g_valid) | ~g_en);

    src_ready_o              = '0;
    src_ready_o[grant_idx_o] = g_ready;

    state_d = state_q;
    case (state_q)
      S_IDLE:  if (found) state_d = S_GRANT;
      S_GRANT: if (exit_grant) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

`ifdef I2S_ARB_SILENCE_FILL_EN
    // A frame being accepted this cycle frees the slot, so silence can follow back to back.
    fill    = ~busy & ~found & (~dst_valid_o | dst_ready_i);
    und_inc = fill;
`else
    fill    = 1'b0;
    und_inc = dst_ready_i & ~dst_valid_o;
`endif
  end

  always_ff @(posedge aud_mclk) begin
    if (aud_mrst) begin
      state_q        <= S_IDLE;
      last_q         <= IW'(NUM_SRC - 1);
      burst_q        <= '0;
      dst_valid_o    <= 1'b0;
      dst_data_o     <= '0;
      grant_idx_o    <= '0;
      underrun_cnt_o <= '0;
    end else begin
      state_q <= state_d;
      if (!busy && found) begin
        grant_idx_o <= winner;
        burst_q     <= '0;
      end
      if (xfer) burst_q <= burst_q + CW'(1);
      if (exit_grant) last_q <= grant_idx_o;

      if (xfer) begin
        dst_data_o  <= g_frame;
        dst_valid_o <= 1'b1;
      end else if (fill) begin
        dst_data_o  <= '0;
        dst_valid_o <= 1'b1;
      end else if (dst_ready_i) begin
        dst_valid_o <= 1'b0;
      end

      if (und_inc && underrun_cnt_o != 16'hFFFF) underrun_cnt_o <= underrun_cnt_o + 16'd1;
    end
  end

  assign busy_o      = busy;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_i2s_src_arbiter.sv
// Bench for i2s_src_arbiter: directed scenarios plus random traffic against a cycle model
// built from the arbitration rules, with a frame scoreboard on the output channel.
module tb_i2s_src_arbiter;
  import i2s_pkg::*;

  localparam int NUM_SRC   = 4;
  localparam int DATA_W    = 32;
  localparam int BURST_LEN = 8;
  localparam int IW        = $clog2(NUM_SRC);

  logic                      aud_mclk = 1'b0;
  logic                      aud_mrst;
  logic [NUM_SRC*DATA_W-1:0] src_data_i;
  logic [NUM_SRC-1:0]        src_valid_i;
  logic [NUM_SRC-1:0]        src_ready_o;
  logic [NUM_SRC-1:0]        src_en_i;
  logic [DATA_W-1:0]         dst_data_o;
  logic                      dst_valid_o;
  logic                      dst_ready_i;
  logic [IW-1:0]             grant_idx_o;
  logic                      busy_o;
  logic [15:0]               underrun_cnt_o;
  arb_state_t                dbg_state_o;

  int vectors = 0;
  int errors  = 0;

  i2s_src_arbiter #(.NUM_SRC(NUM_SRC), .DATA_W(DATA_W), .BURST_LEN(BURST_LEN)) dut (
    .aud_mclk       (aud_mclk),
    .aud_mrst       (aud_mrst),
    .src_data_i     (src_data_i),
    .src_valid_i    (src_valid_i),
    .src_ready_o    (src_ready_o),
    .src_en_i       (src_en_i),
    .dst_data_o     (dst_data_o),
    .dst_valid_o    (dst_valid_o),
    .dst_ready_i    (dst_ready_i),
    .grant_idx_o    (grant_idx_o),
    .busy_o         (busy_o),
    .underrun_cnt_o (underrun_cnt_o),
    .dbg_state_o    (dbg_state_o)
  );

  // clock / watchdog
  always #5 aud_mclk = ~aud_mclk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // scoreboard and model
  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] del_log[$];

  bit                m_known = 1'b0;
  int                m_g, m_gidx, m_last, m_burst, m_und;
  bit                m_ov, nov, rdy, done, und_inc;
  logic [DATA_W-1:0] m_od, frm;
  logic [NUM_SRC-1:0] exp_rdy;
  int                pick, k;

  always @(negedge aud_mclk) begin
    if (m_known) begin
      exp_rdy = '0;
      if (m_g >= 0 && src_en_i[m_g] && (!m_ov || dst_ready_i)) exp_rdy[m_g] = 1'b1;
      chk("src_ready", src_ready_o, exp_rdy);
      chk("dst_valid", dst_valid_o, m_ov);
      if (m_ov) chk("dst_data", dst_data_o, m_od);
      chk("busy", busy_o, m_g >= 0);
      chk("dbg_state", dbg_state_o == S_GRANT, m_g >= 0);
      chk("grant_idx", grant_idx_o, m_gidx);
      chk("underrun", underrun_cnt_o, m_und);
      if (dst_valid_o && dst_ready_i && !aud_mrst) begin
        if (exp_q.size() == 0) begin
          vectors++;
          errors++;
          $display("FAIL sb_frame: got frame %0h, expected no frame", dst_data_o);
        end else begin
          chk("sb_frame", dst_data_o, exp_q.pop_front());
        end
        del_log.push_back(dst_data_o);
      end
    end

    if (aud_mrst) begin
      m_g = -1; m_gidx = 0; m_last = NUM_SRC - 1; m_burst = 0;
      m_ov = 0; m_od = '0; m_und = 0;
      exp_q.delete();
      m_known = 1'b1;
    end else if (m_known) begin
`ifdef I2S_ARB_SILENCE_FILL_EN
      und_inc = 1'b0;
`else
      und_inc = dst_ready_i && !m_ov;
`endif
      nov = m_ov;
      if (m_ov && dst_ready_i) nov = 1'b0;
      if (m_g < 0) begin
        pick = -1;
        for (int i = 1; i <= NUM_SRC; i++) begin
          k = (m_last + i) % NUM_SRC;
          if (pick < 0 && src_valid_i[k] && src_en_i[k]) pick = k;
        end
        if (pick >= 0) begin
          m_g = pick; m_gidx = pick; m_burst = 0;
        end
`ifdef I2S_ARB_SILENCE_FILL_EN
        else if (!m_ov || dst_ready_i) begin
          nov = 1'b1; m_od = '0; exp_q.push_back('0); und_inc = 1'b1;
        end
`endif
      end else begin
        rdy  = src_en_i[m_g] && (!m_ov || dst_ready_i);
        done = 1'b0;
        if (rdy && src_valid_i[m_g]) begin
          frm = src_data_i[m_g*DATA_W +: DATA_W];
          nov = 1'b1; m_od = frm; exp_q.push_back(frm);
          m_burst++;
          done = (m_burst == BURST_LEN);
        end
        if (done || (rdy && !src_valid_i[m_g]) || !src_en_i[m_g]) begin
          m_last = m_g; m_g = -1;
        end
      end
      m_ov = nov;
      if (und_inc && m_und < 16'hFFFF) m_und++;
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge aud_mclk);
    #1;
  endtask

  task automatic do_reset();
    aud_mrst    = 1'b1;
    src_valid_i = '0;
    tick();
    aud_mrst = 1'b0;
  endtask

  task automatic set_data(input int s, input logic [DATA_W-1:0] v);
    src_data_i[s*DATA_W +: DATA_W] = v;
  endtask

  function automatic logic [DATA_W-1:0] frame_of(input int s);
    aud_frame_t f;
    f.l = 16'hA000 | 16'(s);
    f.r = 16'h5000 | 16'(s);
    return f;
  endfunction

  function automatic int count_in_log(input logic [DATA_W-1:0] v);
    int n = 0;
    foreach (del_log[i]) if (del_log[i] == v) n++;
    return n;
  endfunction

  int acc;

  initial begin
    aud_mrst = 1'b1; src_data_i = '0; src_valid_i = '0; src_en_i = '0; dst_ready_i = 1'b0;
    tick(); tick();
    chk("rst_dst_valid", dst_valid_o, 0);
    chk("rst_dst_data", dst_data_o, 0);
    chk("rst_grant", grant_idx_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_underrun", underrun_cnt_o, 0);
    chk("rst_src_ready", src_ready_o, 0);

    // idle underrun counting and saturation
    aud_mrst = 1'b0; dst_ready_i = 1'b1;
    repeat (10) tick();
    chk("underrun_10", underrun_cnt_o, 10);
    repeat (65530) tick();
    chk("underrun_sat", underrun_cnt_o, 16'hFFFF);

    // two continuous sources alternate in full bursts
    do_reset();
    src_en_i = '1;
    for (int s = 0; s < NUM_SRC; s++) set_data(s, frame_of(s));
    src_valid_i = 4'b0101; dst_ready_i = 1'b1;
    del_log.delete();
    repeat (40) tick();
    chk("burst_log_len", del_log.size() >= 32, 1);
    if (del_log.size() >= 32)
      for (int i = 0; i < 32; i++)
        chk($sformatf("burst_seq%0d", i), del_log[i], frame_of(((i / 8) % 2) * 2));

    // short source ends its grant; next grant wraps to src0
    do_reset();
    src_en_i = '1; src_valid_i = 4'b0010; dst_ready_i = 1'b1;
    del_log.delete(); acc = 0;
    for (int c = 0; c < 20 && acc < 3; c++) begin
      #1;
      if (src_ready_o[1]) acc++;
      tick();
    end
    src_valid_i = 4'b0001;
    tick(); tick();
    chk("short_grant_idx", grant_idx_o, 0);
    chk("short_busy", busy_o, 1);
    repeat (3) tick();
    chk("short_src1_frames", count_in_log(frame_of(1)), 3);
    chk("short_next_src0", del_log.size() > 3 ? del_log[3] : '0, frame_of(0));

    // output stall holds data and blocks all sources
    do_reset();
    src_en_i = 4'b0001; set_data(0, 32'h1234_5678); src_valid_i = 4'b0001; dst_ready_i = 1'b0;
    del_log.delete();
    tick(); tick();
    src_valid_i = '0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("stall_valid", dst_valid_o, 1);
      chk("stall_data", dst_data_o, 32'h1234_5678);
      chk("stall_ready", src_ready_o, 0);
      tick();
    end
    dst_ready_i = 1'b1;
    tick(); tick();
    chk("stall_once", count_in_log(32'h1234_5678), 1);

    // enable drop mid-burst keeps the pending frame
    do_reset();
    src_en_i = '1; set_data(1, frame_of(1)); src_valid_i = 4'b0010; dst_ready_i = 1'b1;
    tick(); tick(); tick();
    src_en_i = 4'b1101; dst_ready_i = 1'b0;
    #1;
    chk("en_drop_ready", src_ready_o, 0);
    tick();
    chk("en_drop_idle", busy_o, 0);
    chk("en_drop_pending", dst_valid_o, 1);
    chk("en_drop_data", dst_data_o, frame_of(1));
    dst_ready_i = 1'b1;
    del_log.delete();
    tick();
    chk("en_drop_delivered", del_log.size() > 0 ? del_log[0] : '0, frame_of(1));

    // reset mid-burst, then src0 wins first
    do_reset();
    src_en_i = '1;
    for (int s = 0; s < NUM_SRC; s++) set_data(s, frame_of(s));
    src_valid_i = 4'b0100; dst_ready_i = 1'b1;
    repeat (4) tick();
    aud_mrst = 1'b1;
    tick();
    chk("mrst_dst_valid", dst_valid_o, 0);
    chk("mrst_dst_data", dst_data_o, 0);
    chk("mrst_busy", busy_o, 0);
    chk("mrst_grant", grant_idx_o, 0);
    chk("mrst_underrun", underrun_cnt_o, 0);
    chk("mrst_src_ready", src_ready_o, 0);
    aud_mrst = 1'b0; src_valid_i = '1;
    del_log.delete();
    tick();
    chk("mrst_first_busy", busy_o, 1);
    tick(); tick();
    chk("mrst_first_frame", del_log.size() > 0 ? del_log[0] : '0, frame_of(0));

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      aud_mrst = ($urandom_range(0, 299) == 0);
      for (int s = 0; s < NUM_SRC; s++) begin
        src_valid_i[s] = ($urandom_range(0, 3) != 0);
        set_data(s, $urandom);
      end
      src_en_i    = ($urandom_range(0, 7) == 0) ? NUM_SRC'($urandom) : '1;
      dst_ready_i = ($urandom_range(0, 2) != 0);
      tick();
    end
    aud_mrst = 1'b0; src_valid_i = '0; dst_ready_i = 1'b1;
    repeat (20) tick();
    chk("sb_drain", exp_q.size() <= 1, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
